mask_centroid: RTL

// - Consumes the 1-bit green/user mask stream produced by the hue-threshold stage and reduces each frame to a user summary.
// - Summary: pixel count, centroid (x,y) and bounding box. Feeds pose comparison/scoring logic downstream.
// - Accumulates sums on the fly. At frame end, snapshots the sums and runs two sequential divisions for the centroid.

---
 rtl/user_extraction_pkg.sv | 39 +++
 rtl/seq_divider.sv | 67 ++++++
 rtl/mask_centroid.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/user_extraction_pkg.sv
// Shared widths, FSM encoding and per-frame statistics types for the mask centroid block.
// Pure types and constants; no timing or flow control of its own.
package user_extraction_pkg;

  localparam int H_ACTIVE_DEF  = 320;
  localparam int V_ACTIVE_DEF  = 240;
  localparam int MIN_COUNT_DEF = 16;

  localparam int SUM_W = 25;
  localparam int CNT_W = 17;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} centroid_state_t;

  typedef struct packed {
    logic [X_W-1:0] xmin;
    logic [X_W-1:0] xmax;
    logic [Y_W-1:0] ymin;
    logic [Y_W-1:0] ymax;
  } bbox_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
    bbox_t            bbox;
  } frame_stats_t;

  // Empty-frame accumulator: mins parked at their largest value so the first hit replaces them.
  function automatic frame_stats_t stats_init();
    frame_stats_t s;
    s           = '0;
    s.bbox.xmin = '1;
    s.bbox.ymin = '1;
    return s;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; start performs the first iteration.
// Latency N_W cycles from start to a one-cycle done pulse; a start while running restarts it.
module seq_divider #(
  parameter int N_W = 25,
  parameter int D_W = 17,
  parameter int Q_W = N_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [Q_W-1:0] quotient,
  output logic           done
);

  localparam int C_W = $clog2(N_W + 1);

  logic [D_W-1:0] rem, rem_src, rem_nxt, dsr, dsr_src;
  logic [N_W-1:0] quo, quo_src, quo_nxt;
  logic [D_W:0]   trial;
  logic           ge;
  logic [C_W-1:0] cnt;
  logic           running;

  always_comb begin
    rem_src = start ? '0 : rem;
    quo_src = start ? dividend : quo;
    dsr_src = start ? divisor : dsr;
    trial   = {rem_src, quo_src[N_W-1]};
    ge      = (trial >= {1'b0, dsr_src});
    // When ge holds the true difference is below the divisor, so D_W bits suffice.
    rem_nxt = ge ? (trial[D_W-1:0] - dsr_src) : trial[D_W-1:0];
    quo_nxt = {quo_src[N_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= rem_nxt;
        quo     <= quo_nxt;
        dsr     <= divisor;
        cnt     <= C_W'(N_W - 1);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == C_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/mask_centroid.sv
// Reduces a 1-bit mask stream to per-frame count, centroid and bounding box.
// Result 52 cycles after frame end (2 when too few pixels); no input stall, frames ending while busy are dropped.
module mask_centroid
  import user_extraction_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_in,
  input  logic             mask_valid,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic [X_W-1:0]   bbox_xmin,
  output logic [X_W-1:0]   bbox_xmax,
  output logic [Y_W-1:0]   bbox_ymin,
  output logic [Y_W-1:0]   bbox_ymax,
  output logic             user_present,
  output logic             result_valid,
  output logic             busy,
  output logic             frame_dropped
);

  localparam logic [10:0]      H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0]      H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]       V_LIM  = 10'(V_ACTIVE);
  localparam logic [9:0]       V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_COUNT);

  function automatic logic is_skip(input logic [CNT_W-1:0] c);
    return (c == '0) || (c < MIN_C);
  endfunction

  logic           accept, hit, frame_end_q;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  frame_stats_t   acc, acc_base, acc_nxt;

  assign accept = mask_valid && (hcount < H_LIM) && (vcount < V_LIM);
  assign hit    = accept && mask_in;
  assign px     = hcount[X_W-1:0];
  assign py     = vcount[Y_W-1:0];

  // The edge after frame end clears and accumulates the new frame's first sample together.
  always_comb begin
    acc_base = frame_end_q ? stats_init() : acc;
    acc_nxt  = acc_base;
    if (hit) begin
      acc_nxt.count = acc_base.count + CNT_W'(1);
      acc_nxt.sum_x = acc_base.sum_x + SUM_W'(px);
      acc_nxt.sum_y = acc_base.sum_y + SUM_W'(py);
      if (px < acc_base.bbox.xmin) acc_nxt.bbox.xmin = px;
      if (px > acc_base.bbox.xmax) acc_nxt.bbox.xmax = px;
      if (py < acc_base.bbox.ymin) acc_nxt.bbox.ymin = py;
      if (py > acc_base.bbox.ymax) acc_nxt.bbox.ymax = py;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= stats_init();
      frame_end_q <= 1'b0;
    end else begin
      acc         <= acc_nxt;
      frame_end_q <= accept && (hcount == H_LAST) && (vcount == V_LAST);
    end
  end

  centroid_state_t  state, state_nxt;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [X_W-1:0]   div_q, quo_x;
  logic [CNT_W-1:0] snap_count;
  logic [SUM_W-1:0] snap_sum_y;
  bbox_t            snap_bbox;

  seq_divider #(
    .N_W(SUM_W),
    .D_W(CNT_W),
    .Q_W(X_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_q),
    .done     (div_done)
  );

  // X division starts straight from the live accumulator on the snapshot edge.
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = acc.sum_x;
    div_divisor  = acc.count;
    case (state)
      IDLE: begin
        if (frame_end_q) begin
          if (is_skip(acc.count)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DIV_X;
            div_start = 1'b1;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          state_nxt    = DIV_Y;
          div_start    = 1'b1;
          div_dividend = snap_sum_y;
          div_divisor  = snap_count;
        end
      end
      DIV_Y:   if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_count <= '0;
      snap_sum_y <= '0;
      snap_bbox  <= '0;
      quo_x      <= '0;
    end else begin
      if (state == IDLE && frame_end_q) begin
        snap_count <= acc.count;
        snap_sum_y <= acc.sum_y;
        snap_bbox  <= acc.bbox;
      end
      if (state == DIV_X && div_done) quo_x <= div_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      centroid_x    <= '0;
      centroid_y    <= '0;
      pixel_count   <= '0;
      bbox_xmin     <= '0;
      bbox_xmax     <= '0;
      bbox_ymin     <= '0;
      bbox_ymax     <= '0;
      user_present  <= 1'b0;
      result_valid  <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      result_valid  <= 1'b0;
      frame_dropped <= frame_end_q && (state != IDLE);
      if (state == DONE) begin
        result_valid <= 1'b1;
        pixel_count  <= snap_count;
        if (is_skip(snap_count)) begin
          centroid_x   <= '0;
          centroid_y   <= '0;
          bbox_xmin    <= '0;
          bbox_xmax    <= '0;
          bbox_ymin    <= '0;
          bbox_ymax    <= '0;
          user_present <= 1'b0;
        end else begin
          centroid_x   <= quo_x;
          centroid_y   <= div_q[Y_W-1:0];
          bbox_xmin    <= snap_bbox.xmin;
          bbox_xmax    <= snap_bbox.xmax;
          bbox_ymin    <= snap_bbox.ymin;
          bbox_ymax    <= snap_bbox.ymax;
          user_present <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
